// File: rtl/mtl1_bus_pkg.sv
// mtl1_bus_pkg: shared FSM encoding and window constants for the 6809 flash bridge
package mtl1_bus_pkg;
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WDATA = 3'd1;
   localparam logic [2:0] REQ   = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] HOLD  = 3'd4;
   localparam logic [15:0] FLASH_WIN_BASE = 16'hE000;
   localparam logic [15:0] FLASH_WIN_MASK = 16'hF000;
   localparam logic [7:0]  BUS_FLOAT      = 8'hFF;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser with one-cycle rise/fall strobes
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sr;
   logic prev;
   always_ff @(posedge clk) begin
      if (!reset) begin
         sr   <= '0;
         prev <= 1'b0;
      end else begin
         sr   <= {sr[STAGES-2:0], d};
         prev <= sr[STAGES-1];
      end
   end
   assign level = sr[STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;
endmodule

// File: rtl/mc6809_flash_bus_bridge.sv
// mc6809_flash_bus_bridge: 6809 bus front-end that turns flash-window cycles into
// a single clk-domain request/done handshake, stretching the CPU via MRDY.
module mc6809_flash_bus_bridge
   import mtl1_bus_pkg::*;
#(
   parameter logic [15:0] WIN_BASE       = FLASH_WIN_BASE,
   parameter logic [15:0] WIN_MASK       = FLASH_WIN_MASK,
   parameter int          SYNC_STAGES    = 2,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_E,
   input  logic        i_Q,
   input  logic        i_RW,
   input  logic [15:0] i_ADDRESS_BUS,
   input  logic [7:0]  i_DataBus,
   output logic        o_req,
   output logic        o_req_rw,
   output logic [11:0] o_req_addr,
   output logic [7:0]  o_req_wdata,
   input  logic        i_done,
   input  logic [7:0]  i_rdata,
   output logic [7:0]  o_data_out,
   output logic        o_data_oe,
   output logic        o_MemoryReady,
   output logic        o_timeout
);
   logic [2:0]  state;
   logic [15:0] count;
   logic e_lvl, e_rise, e_fall, q_lvl, q_rise, q_fall, rw_lvl, rw_rise, rw_fall;
   logic hit, accept, to_hit, unused_sync;

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_e (
      .clk(clk), .reset(reset), .d(i_E), .level(e_lvl), .rise(e_rise), .fall(e_fall));
   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_q (
      .clk(clk), .reset(reset), .d(i_Q), .level(q_lvl), .rise(q_rise), .fall(q_fall));
   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_rw (
      .clk(clk), .reset(reset), .d(i_RW), .level(rw_lvl), .rise(rw_rise), .fall(rw_fall));

   assign unused_sync = ^{e_lvl, e_rise, q_lvl, rw_rise, rw_fall};
   assign hit    = (i_ADDRESS_BUS & WIN_MASK) == WIN_BASE;
   assign accept = (state == IDLE) && q_rise && hit;
   assign to_hit = count == TIMEOUT_CYCLES - 16'd1;
   assign o_req  = state == REQ;
   // MRDY drops combinationally in the accepting cycle so the CPU is held from qrise on
   assign o_MemoryReady = !(accept || state == WDATA || state == REQ || state == WAIT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         count       <= '0;
         o_req_rw    <= 1'b1;
         o_req_addr  <= '0;
         o_req_wdata <= '0;
         o_data_out  <= '0;
         o_data_oe   <= 1'b0;
         o_timeout   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               o_req_addr <= i_ADDRESS_BUS[11:0];
               o_req_rw   <= rw_lvl;
               state      <= rw_lvl ? REQ : WDATA;
            end
            WDATA: if (q_fall) begin
               o_req_wdata <= i_DataBus;
               state       <= REQ;
            end
            REQ: begin
               count <= '0;
               state <= WAIT;
            end
            WAIT: begin
               count <= count + 16'd1;
               if (i_done || to_hit) begin
                  if (o_req_rw) begin
                     o_data_out <= i_done ? i_rdata : BUS_FLOAT;
                     o_data_oe  <= 1'b1;
                  end
                  o_timeout <= o_timeout | !i_done;
                  state     <= HOLD;
               end
            end
            HOLD: if (e_fall) begin
               o_data_oe <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mc6809_flash_bus_bridge.sv
// tb_mc6809_flash_bus_bridge: directed plus randomized bus cycles checked against a
// transaction-level model of the bridge (window hit, done-vs-timeout outcome, sticky flag).
module tb_mc6809_flash_bus_bridge;
   localparam int TO = 16;
   logic clk = 1'b0;
   logic reset, e, q, rw, done;
   logic [15:0] addr;
   logic [7:0]  dbus, rdata;
   logic        o_req, o_req_rw, o_data_oe, o_mrdy, o_timeout;
   logic [11:0] o_req_addr;
   logic [7:0]  o_req_wdata, o_data_out;
   int n_vec = 0, n_bad = 0;
   logic [7:0] exp_dout = 8'h00;
   logic       exp_to = 1'b0;

   mc6809_flash_bus_bridge #(.TIMEOUT_CYCLES(16'(TO))) dut (
      .clk(clk), .reset(reset), .i_E(e), .i_Q(q), .i_RW(rw),
      .i_ADDRESS_BUS(addr), .i_DataBus(dbus),
      .o_req(o_req), .o_req_rw(o_req_rw), .o_req_addr(o_req_addr), .o_req_wdata(o_req_wdata),
      .i_done(done), .i_rdata(rdata),
      .o_data_out(o_data_out), .o_data_oe(o_data_oe),
      .o_MemoryReady(o_mrdy), .o_timeout(o_timeout));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // d = cycles after the o_req cycle at which i_done pulses (0 = during REQ, ignored)
   task automatic run_txn(input logic [15:0] a, input logic r, input logic [7:0] wd,
                          input int d, input logic [7:0] rd);
      logic hit, to;
      int end_j;
      hit   = (a & 16'hF000) == 16'hE000;
      valid_check: begin end
      to    = !(d >= 1 && d <= TO);
      end_j = to ? TO : d;
      addr = a; rw = r; dbus = wd; q = 1'b1;
      tick; tick;
      chk("accept_mrdy", o_mrdy, !hit);
      chk("accept_req", o_req, 1'b0);
      if (!hit) begin
         e = 1'b1; tick;
         chk("miss_mrdy", o_mrdy, 1'b1);
         q = 1'b0; tick; tick; tick;
         chk("miss_req", o_req, 1'b0);
         e = 1'b0; tick; tick; tick; tick;
         chk("miss_mrdy_end", o_mrdy, 1'b1);
         chk("miss_oe", o_data_oe, 1'b0);
         return;
      end
      if (!r) begin
         e = 1'b1; tick;
         chk("wdata_mrdy", o_mrdy, 1'b0);
         q = 1'b0; tick; tick;
         chk("qfall_req", o_req, 1'b0);
         tick;
      end else begin
         tick;
      end
      chk("req_pulse", o_req, 1'b1);
      chk("req_addr", o_req_addr, a[11:0]);
      chk("req_rw", o_req_rw, r);
      chk("req_mrdy", o_mrdy, 1'b0);
      if (!r) chk("req_wdata", o_req_wdata, wd);
      e = 1'b1; q = 1'b0; dbus = ~wd;
      done = (d == 0); rdata = $urandom;
      for (int j = 1; j <= end_j; j++) begin
         tick;
         chk("wait_mrdy", o_mrdy, 1'b0);
         chk("wait_req", o_req, 1'b0);
         done  = (j == d);
         rdata = (j == d) ? rd : 8'($urandom);
         q     = (j == 2);
      end
      tick;
      done = 1'b0; q = 1'b0;
      exp_to = exp_to | to;
      if (r) exp_dout = to ? 8'hFF : rd;
      chk("rel_mrdy", o_mrdy, 1'b1);
      chk("rel_timeout", o_timeout, exp_to);
      chk("rel_oe", o_data_oe, r);
      chk("rel_dout", o_data_out, exp_dout);
      if (to) begin
         done = 1'b1; rdata = ~exp_dout; tick; done = 1'b0;
         chk("hold_done_ignored", o_data_out, exp_dout);
      end
      e = 1'b0; tick; tick;
      chk("efall_oe", o_data_oe, r);
      tick;
      chk("idle_oe", o_data_oe, 1'b0);
      chk("idle_mrdy", o_mrdy, 1'b1);
      chk("idle_req", o_req, 1'b0);
      tick;
   endtask

   initial begin
      reset = 1'b0; e = 1'b0; q = 1'b0; rw = 1'b1; done = 1'b0;
      addr = 16'h0000; dbus = 8'h00; rdata = 8'h00;
      tick; tick; tick;
      chk("rst_req", o_req, 1'b0);
      chk("rst_req_rw", o_req_rw, 1'b1);
      chk("rst_addr", o_req_addr, 12'h000);
      chk("rst_wdata", o_req_wdata, 8'h00);
      chk("rst_dout", o_data_out, 8'h00);
      chk("rst_oe", o_data_oe, 1'b0);
      chk("rst_mrdy", o_mrdy, 1'b1);
      chk("rst_timeout", o_timeout, 1'b0);
      reset = 1'b1; tick; tick;
      run_txn(16'hE123, 1'b1, 8'h00, 10, 8'h5A);
      run_txn(16'hEFFF, 1'b0, 8'hC3, 3, 8'h00);
      run_txn(16'hD000, 1'b1, 8'h00, 4, 8'h11);
      run_txn(16'hE800, 1'b1, 8'h00, 99, 8'h77);
      addr = 16'hE010; rw = 1'b1; q = 1'b1;
      tick; tick; tick;
      chk("rstw_req", o_req, 1'b1);
      e = 1'b1; q = 1'b0; tick; tick; tick;
      chk("rstw_wait_mrdy", o_mrdy, 1'b0);
      reset = 1'b0; tick;
      chk("rstw_mrdy", o_mrdy, 1'b1);
      chk("rstw_oe", o_data_oe, 1'b0);
      chk("rstw_timeout", o_timeout, 1'b0);
      e = 1'b0; reset = 1'b1; exp_to = 1'b0; exp_dout = 8'h00;
      done = 1'b1; rdata = 8'hAA; tick; done = 1'b0; tick;
      chk("rstw_done_ignored", o_data_out, 8'h00);
      chk("rstw_req_after", o_req, 1'b0);
      chk("rstw_oe_after", o_data_oe, 1'b0);
      tick; tick;
      run_txn(16'hE456, 1'b1, 8'h00, TO, 8'h3C);
      for (int k = 0; k < 24; k++) begin
         logic [15:0] a;
         a = $urandom_range(0, 1) ? {4'hE, 12'($urandom)} : 16'($urandom);
         run_txn(a, 1'($urandom), 8'($urandom), int'($urandom_range(0, 20)), 8'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/mc6809_flash_bus_bridge.md
Name: mc6809_flash_bus_bridge

Overview:
- Front-end stage between the 6809 bus and the SPI flash controller.
- Synchronises the 6809 E/Q/RW strobes into the clk domain, decodes the flash address window, latches address/data and issues a single-cycle request to the flash controller.
- Stretches the bus cycle via MRDY until the controller signals done, then returns read data to the CPU.
- Replaces the controller's direct use of E edges as clocks with one clk-domain handshake.

Parameters:
- WIN_BASE, 16'hE000, base address of flash window; must be 4 KB aligned.
- WIN_MASK, 16'hF000, address bits compared against WIN_BASE.
- SYNC_STAGES, 2, flip-flop depth of the E/Q/RW synchronisers (>=2).
- TIMEOUT_CYCLES, 16'd4096, clk cycles allowed in WAIT before forced release.

Ports:
- clk  in  1  system clock; must be >=16x E frequency.
- reset  in  1  synchronous, active-low.
- i_E  in  1  6809 E clock (asynchronous).
- i_Q  in  1  6809 Q clock (asynchronous).
- i_RW  in  1  6809 R/W; 1 = read.
- i_ADDRESS_BUS  in  16  6809 address.
- i_DataBus  in  8  6809 write data.
- o_req  out  1  one-cycle request pulse to flash controller.
- o_req_rw  out  1  latched R/W for the request.
- o_req_addr  out  12  latched address bits [11:0].
- o_req_wdata  out  8  latched write data.
- i_done  in  1  one-cycle completion pulse from flash controller.
- i_rdata  in  8  read data; valid when i_done is high.
- o_data_out  out  8  data driven to the 6809.
- o_data_oe  out  1  enable for the CPU data-bus driver.
- o_MemoryReady  out  1  6809 MRDY; 0 stretches the cycle.
- o_timeout  out  1  sticky flag: a WAIT timeout has occurred.

Behaviour:

Reset (reset==0 on a clk edge):
- state=IDLE.
- o_req=0, o_req_rw=1, o_req_addr=0, o_req_wdata=0.
- o_data_out=0, o_data_oe=0, o_MemoryReady=1, o_timeout=0.
- Timeout counter=0; synchronisers cleared.
- Reset mid-transaction abandons the cycle immediately: MRDY released, no further o_req. Any in-flight controller operation is not tracked.

Synchronisation and edge detection:
- E, Q and RW each pass through SYNC_STAGES flops.
- Edge detectors on the synchronised E and Q produce qrise, qfall and efall, each one cycle wide.
- Address/data are sampled raw. They are stable while Q/E are high, so the sampling is safe after synchronisation.

Window hit:
- hit = ((i_ADDRESS_BUS & WIN_MASK) == WIN_BASE).

FSM:
- IDLE: on qrise && hit:
  - latch o_req_addr = addr[11:0] and o_req_rw = synchronised RW.
  - o_MemoryReady <= 0.
  - next = REQ if read, WDATA if write.
  - qrise without hit: stay in IDLE.
- WDATA: on qfall, latch o_req_wdata = i_DataBus, then go to REQ.
- REQ: o_req=1 for exactly one cycle, then WAIT. Clear the timeout counter.
- WAIT: counter increments each cycle.
  - On i_done: if read, o_data_out <= i_rdata and o_data_oe <= 1. Then o_MemoryReady <= 1, next HOLD.
  - On counter == TIMEOUT_CYCLES-1 without i_done: o_timeout <= 1, o_MemoryReady <= 1. If read, o_data_out <= 8'hFF and o_data_oe <= 1. Next HOLD.
  - i_done and timeout in the same cycle: i_done wins; o_timeout is not set.
- HOLD: on efall, o_data_oe <= 0, next IDLE.

Boundary rules:
- Latency: qrise to o_req = 1 cycle for reads; qfall+1 for writes.
- i_done is ignored in IDLE, WDATA, REQ and HOLD.
- A qrise outside IDLE is ignored, so there is no queueing.
- o_MemoryReady is 0 only in REQ, WDATA and WAIT. It is also 0 during the IDLE cycle that accepts a hit.
- Counter width is 16 bits, compared against TIMEOUT_CYCLES-1. The counter does not wrap because it exits WAIT at the limit.
- o_timeout stays set until reset.

Decomposition:
- Package mtl1_bus_pkg:
  - state encoding IDLE/WDATA/REQ/WAIT/HOLD (3-bit);
  - default window constants FLASH_WIN_BASE and FLASH_WIN_MASK;
  - the 8'hFF bus-float data value.
- One natural sub-module: sync_edge_detect (parameterised depth; outputs synchronised level, rise, fall). Instantiated for E, Q and RW.

Test Plan:
- Read hit 0xE123, i_done 10 cycles after o_req with i_rdata=8'h5A → o_req_addr=12'h123, o_req_rw=1; MRDY low from qrise until the i_done cycle; o_data_out=8'h5A with o_data_oe high until efall.
- Write 0xEFFF, data 8'hC3 → o_req fires 1 cycle after qfall with o_req_wdata=8'hC3, o_req_addr=12'hFFF, o_req_rw=0; o_data_oe stays 0 throughout.
- Access 0xD000 → no o_req, MRDY stays 1, state remains IDLE.
- Read hit with no i_done, TIMEOUT_CYCLES=16 → MRDY released 16 cycles after REQ; o_timeout=1; o_data_out=8'hFF.
- reset asserted in WAIT → next cycle MRDY=1, o_data_oe=0, state IDLE; a later i_done is ignored; the next hit proceeds normally.
- i_done coincident with the timeout cycle → i_rdata is returned and o_timeout stays 0.
